// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and defaults for the RISC-V IF pipeline.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int INSN_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_PC = '0;
   typedef logic [XLEN-1:0] pc_t;
endpackage

// File: rtl/riscv_pc_reg.sv
// Resettable register with hold enable; stores the fetch PC.
module riscv_pc_reg
   import riscv_pkg::*;
#(
   parameter int W = XLEN,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;
endmodule

// File: rtl/riscv_fetch_pc.sv
// IF-stage PC generator: sequential advance, stall hold, redirect load.
// Optional bubble counter enabled by RISCV_FETCH_STALL_CNT_EN.
module riscv_fetch_pc #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
   parameter int INSN_BYTES = riscv_pkg::INSN_BYTES
) (
   input  logic            rst,
   input  logic            clk,
   input  logic            bubble,
   output logic [XLEN-1:0] pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc_next
`ifdef RISCV_FETCH_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);
   import riscv_pkg::*;

   logic            w_redir;
   logic            w_pc_en;
   logic [XLEN-1:0] w_pc_seq;
   logic [XLEN-1:0] w_pc_tgt;
   logic [XLEN-1:0] w_pc_nxt;

   // An unconnected redirect floats to Z/X and must read as inactive.
   assign w_redir  = (redirect === 1'b1);
   assign w_pc_seq = pc + XLEN'(INSN_BYTES);
   assign w_pc_tgt = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_pc_en  = w_redir | ~bubble;

   always_comb begin
      w_pc_nxt = pc;
      if (w_redir) begin
         w_pc_nxt = w_pc_tgt;
      end else if (!bubble) begin
         w_pc_nxt = w_pc_seq;
      end
   end

   riscv_pc_reg #(
      .W         (XLEN),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_pc_en),
      .i_d  (w_pc_nxt),
      .o_q  (pc)
   );

   assign pc_next = w_pc_nxt;

`ifdef RISCV_FETCH_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (bubble && !w_redir && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_riscv_fetch_pc.sv
// Randomized self-checking bench for riscv_fetch_pc against a PC model.
module tb_riscv_fetch_pc;
   import riscv_pkg::*;

   logic        rst;
   logic        clk;
   logic        bubble;
   logic [31:0] pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_next;
`ifdef RISCV_FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   pc_t     exp_pc;
   longint  exp_scnt;

   riscv_fetch_pc dut (
      .rst         (rst),
      .clk         (clk),
      .bubble      (bubble),
      .pc          (pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc_next     (pc_next)
`ifdef RISCV_FETCH_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: target rounded down to a word, else hold, else +4 mod 2^32.
   function automatic pc_t model_next(input logic b, input logic r,
                                      input pc_t t, input pc_t cur);
      longint v;
      if (r) begin
         v = longint'(t) - (longint'(t) % 4);
      end else if (b) begin
         v = longint'(cur);
      end else begin
         v = (longint'(cur) + 4) % 64'sh1_0000_0000;
      end
      return pc_t'(v);
   endfunction

   task automatic step(input logic b, input logic r, input logic [31:0] t);
      pc_t nxt;
      bubble      = b;
      redirect    = r;
      redirect_pc = t;
      #1;
      nxt = model_next(b, r, t, exp_pc);
      check("pc_next", pc_next, nxt);
      @(posedge clk);
      #1;
      exp_pc = nxt;
      if (b && !r && exp_scnt < 64'hFFFF_FFFF) exp_scnt++;
      check("pc", pc, exp_pc);
`ifdef RISCV_FETCH_STALL_CNT_EN
      check("stall_cnt", stall_cnt, 32'(exp_scnt));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_async", pc, 32'h0);
`ifdef RISCV_FETCH_STALL_CNT_EN
      check("rst_cnt", stall_cnt, 32'h0);
`endif
      @(posedge clk);
      #1;
      check("rst_hold", pc, 32'h0);
      rst      = 1'b0;
      exp_pc   = '0;
      exp_scnt = 0;
   endtask

   initial begin
      rst         = 1'b1;
      bubble      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      exp_pc      = '0;
      exp_scnt    = 0;
      #2;
      check("reset_pc", pc, 32'h0);
      @(posedge clk);
      #1;
      check("reset_held", pc, 32'h0);
      rst = 1'b0;

      step(1'b0, 1'b0, 32'h0);
      check("run_4", pc, 32'd4);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check("run_12", pc, 32'd12);

      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      check("stall_12", pc, 32'd12);
      step(1'b0, 1'b0, 32'h0);
      check("resume_16", pc, 32'd16);

      do_reset();
      step(1'b0, 1'b0, 32'h0);
      check("post_rst_4", pc, 32'd4);

      step(1'b1, 1'b1, 32'h103);
      check("redir_100", pc, 32'h100);
      step(1'b0, 1'b0, 32'h0);
      check("redir_104", pc, 32'h104);

      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      check("wrap_0", pc, 32'h0);

`ifdef RISCV_FETCH_STALL_CNT_EN
      do_reset();
      repeat (5) step(1'b1, 1'b0, 32'h0);
      check("cnt_5", stall_cnt, 32'd5);
      do_reset();
      check("cnt_clr", stall_cnt, 32'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         logic        b;
         logic        r;
         logic [31:0] t;
         if ($urandom_range(99) < 3) begin
            do_reset();
         end else begin
            b = ($urandom_range(99) < 30);
            r = ($urandom_range(99) < 20);
            t = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(7))
                                         : $urandom;
            step(b, r, t);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
